enemy_rom_scheduler: RTL and testbench
======================================

Name: enemy_rom_scheduler

Overview:
- Sequences the single-port enemy sprite ROM (32x32, 12-bit colour, registered row/col address, one-cycle read latency) and shares it among up to NUM_REQ enemy render engines.
- Each requester asks for one sprite row. The scheduler picks a requester round-robin, then streams all SPRITE_W columns of that row from the ROM, tagging each pixel with requester id, column and opacity.
- Sits between the per-enemy draw logic and the ROM instance in the pixel-generation path.

Parameters:
- NUM_REQ, 4, number of requesters
- ID_W, 2, width of requester id; must satisfy 2^ID_W >= NUM_REQ
- ADDR_W, 5, row/col address width
- SPRITE_W, 32, columns per sprite row; must satisfy SPRITE_W <= 2^ADDR_W
- COLOR_W, 12, colour width
- TRANSPARENT, 12'h6CC, background colour treated as see-through

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  permit new grants (low during active video if desired)
- req_valid  in  NUM_REQ  per-requester row request
- req_row  in  NUM_REQ*ADDR_W  requested sprite row, requester i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot accept, combinational in grant cycle
- rom_row  out  ADDR_W  ROM row address
- rom_col  out  ADDR_W  ROM column address
- rom_data  in  COLOR_W  ROM colour output, valid one cycle after address
- px_valid  out  1  pixel output valid
- px_id  out  ID_W  owning requester
- px_col  out  ADDR_W  column of the pixel
- px_color  out  COLOR_W  equals rom_data
- px_opaque  out  1  high when px_color != TRANSPARENT
- px_last  out  1  final column of the burst
- busy  out  1  burst issuing or pixel pending

Behaviour:
- States: IDLE, BURST. Registers: state, rr_ptr, row_l, id_l, col_cnt, pipeline tags (v_q, id_q, col_q, last_q).
- Reset (asynchronous, immediate):
  - state=IDLE, rr_ptr=0, col_cnt=0, rom_row=0, rom_col=0, all tags 0.
  - Outputs px_valid=0, px_last=0, busy=0, req_ready=0.
  - A reset mid-burst abandons the burst; no further pixels are produced.
- Arbitration slot: IDLE, or the final issue cycle of BURST (col_cnt==SPRITE_W-1). It is active only when en=1.
  - Winner is the first i with req_valid[i]=1, scanning from rr_ptr upward modulo NUM_REQ.
  - In the slot cycle, req_ready[winner]=1 and all other bits are 0. Outside a slot, req_ready=0.
- On grant: row_l<=req_row[winner], id_l<=winner, col_cnt<=0, rr_ptr<=(winner+1) mod NUM_REQ, state<=BURST.
- BURST:
  - Each cycle drives rom_row=row_l, rom_col=col_cnt and issues one address.
  - col_cnt increments by 1 per cycle.
  - At SPRITE_W-1: go to BURST again on a new grant, otherwise to IDLE.
- Pipeline tags: in each issue cycle, v_q<=1, id_q<=id_l, col_q<=col_cnt, last_q<=(col_cnt==SPRITE_W-1). In any non-issue cycle, v_q<=0.
- Pixel outputs: px_valid=v_q, px_id=id_q, px_col=col_q, px_last=last_q, px_color=rom_data, px_opaque=(rom_data!=TRANSPARENT).
  - px_color and px_opaque are combinational from rom_data.
- Latency: grant in cycle G; first address issued in G+1; first px_valid in G+2; last pixel in G+1+SPRITE_W.
- Back-to-back bursts produce a gapless px stream.
- en=0 blocks new grants only. An in-flight burst always completes.
- A requester may drop req_valid before being granted, with no side effect. After its req_ready pulse it must deassert req_valid or request again.
- A requester with req_valid held continuously is granted at most once per NUM_REQ grants while others are requesting.
- busy = (state==BURST) | v_q.
- rom_row/rom_col hold their last values in IDLE.

Decomposition:
- Shared package: TRANSPARENT colour, ADDR_W, COLOR_W, sprite dimension constants, and the state encoding (IDLE=0, BURST=1).
- One natural sub-module: rr_arbiter. Inputs: request vector, pointer, enable. Outputs: one-hot grant and winner index. Combinational, reusable for the bomb/explosion ROM schedulers.

Test Plan:
- Single request: reset, en=1, req_valid=4'b0001, row 0 -> req_ready[0] in G. px_valid G+2..G+33, px_id=0, px_col 0..31. Column 0 colour 12'h6CC with px_opaque=0; columns 9 and 10 colour 12'h000 with px_opaque=1; px_last at col 31.
- Fairness: req_valid=4'b1111 held -> grant order 0,1,2,3,0. Bursts are gapless: px_valid stays continuously 1 for 4*32 cycles.
- Enable gating: en=0 with req_valid=4'b0100 -> no req_ready. Raise en -> grant to id 2 the same cycle. Dropping en mid-burst -> all 32 pixels still delivered.
- Pointer wrap: grant id 3, then req_valid=4'b1001 -> next grant is 0, not 3.
- Reset mid-burst: assert reset_n=0 at col 12 -> px_valid, busy and req_ready go 0 immediately. After release, with no request, the block stays IDLE and rr_ptr=0.
- Withdrawn request: req_valid[1] pulses for one cycle while id 0's burst runs, not in its slot -> no grant to id 1, and px_id never equals 1.

Source files
------------

// File: rtl/enemy_rom_scheduler_pkg.sv
// rtl/enemy_rom_scheduler_pkg.sv - shared constants and state encoding for the enemy sprite ROM scheduler
package enemy_rom_scheduler_pkg;

    localparam int SPR_ADDR_W  = 5;
    localparam int SPR_COLOR_W = 12;
    localparam int SPR_W       = 32;
    localparam int SPR_H       = 32;

    localparam logic [SPR_COLOR_W-1:0] SPR_TRANSPARENT = 12'h6CC;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first requester at or above ptr wins
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    function automatic logic [IDX_W-1:0] offset_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = offset_idx(ptr, k);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                winner      = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_rom_scheduler.sv
// rtl/enemy_rom_scheduler.sv - shares the enemy sprite ROM among render engines, one row burst per grant
module enemy_rom_scheduler
    import enemy_rom_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int ADDR_W   = SPR_ADDR_W,
    parameter int SPRITE_W = SPR_W,
    parameter int COLOR_W  = SPR_COLOR_W,
    parameter logic [COLOR_W-1:0] TRANSPARENT = SPR_TRANSPARENT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_row,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]           rom_row,
    output logic [ADDR_W-1:0]           rom_col,
    input  logic [COLOR_W-1:0]          rom_data,
    output logic                        px_valid,
    output logic [ID_W-1:0]             px_id,
    output logic [ADDR_W-1:0]           px_col,
    output logic [COLOR_W-1:0]          px_color,
    output logic                        px_opaque,
    output logic                        px_last,
    output logic                        busy
);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, id_l, id_q, winner;
    logic [ADDR_W-1:0] row_l, col_cnt, col_q;
    logic              v_q, last_q;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0] rows [NUM_REQ];
    logic              issue, last_col, slot, granted;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rows
        assign rows[i] = req_row[i*ADDR_W +: ADDR_W];
    end

    assign issue    = (state == BURST);
    assign last_col = issue && (col_cnt == ADDR_W'(SPRITE_W - 1));
    // reset_n gates the slot so req_ready drops the instant reset asserts
    assign slot     = reset_n && en && (!issue || last_col);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .en     (slot),
        .grant  (grant),
        .winner (winner),
        .found  (granted)
    );

    assign req_ready = grant;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (granted) state_nxt = BURST;
            BURST:   if (last_col) state_nxt = granted ? BURST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            row_l   <= '0;
            id_l    <= '0;
            col_cnt <= '0;
            v_q     <= 1'b0;
            id_q    <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            v_q    <= issue;
            last_q <= last_col;
            if (issue) begin
                id_q  <= id_l;
                col_q <= col_cnt;
            end
            if (granted) begin
                row_l   <= rows[winner];
                id_l    <= winner;
                col_cnt <= '0;
                rr_ptr  <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            end else if (issue && !last_col) begin
                // counter parks on the final column so the ROM address holds while idle
                col_cnt <= col_cnt + ADDR_W'(1);
            end
        end
    end

    assign rom_row   = row_l;
    assign rom_col   = col_cnt;
    assign px_valid  = v_q;
    assign px_id     = id_q;
    assign px_col    = col_q;
    assign px_last   = last_q;
    assign px_color  = rom_data;
    assign px_opaque = (rom_data != TRANSPARENT);
    assign busy      = issue | v_q;

endmodule

// File: tb/tb_enemy_rom_scheduler.sv
// tb/tb_enemy_rom_scheduler.sv - scoreboard bench for enemy_rom_scheduler with a behavioural ROM and arbiter model
module tb_enemy_rom_scheduler;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int CW = 12;
    localparam int SW = 32;
    localparam logic [CW-1:0] TRANSP = 12'h6CC;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             en = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_row = '0;
    logic [NR-1:0]    req_ready;
    logic [AW-1:0]    rom_row, rom_col;
    logic [CW-1:0]    rom_data;
    logic             px_valid, px_opaque, px_last, busy;
    logic [1:0]       px_id;
    logic [AW-1:0]    px_col;
    logic [CW-1:0]    px_color;

    enemy_rom_scheduler dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .req_valid (req_valid),
        .req_row   (req_row),
        .req_ready (req_ready),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .rom_data  (rom_data),
        .px_valid  (px_valid),
        .px_id     (px_id),
        .px_col    (px_col),
        .px_color  (px_color),
        .px_opaque (px_opaque),
        .px_last   (px_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [CW-1:0] rom_f(input logic [AW-1:0] r, input logic [AW-1:0] c);
        if (c == 0) return TRANSP;
        if (c == 9 || c == 10) return 12'h000;
        if (((r + c) & 5'd7) == 5'd5) return TRANSP;
        return {1'b1, r, c, 1'b1};
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_row, rom_col);

    typedef struct {
        int            due;
        logic [1:0]    id;
        logic [AW-1:0] col;
        logic [CW-1:0] color;
    } px_t;

    px_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    // requester state and arbitration model
    logic [NR-1:0] pend = '0;
    logic [AW-1:0] prow [NR];
    int  m_ptr = 0;
    int  m_end = 0;
    bit  sticky = 1'b0;

    task automatic step();
        int w;
        logic [NR-1:0] exp_rdy;
        req_valid = pend;
        for (int i = 0; i < NR; i++) req_row[i*AW +: AW] = prow[i];
        #1;
        w = -1;
        exp_rdy = '0;
        if (reset_n && en && cyc >= m_end)
            for (int k = 0; k < NR; k++)
                if (w < 0 && pend[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (w >= 0) begin
            for (int c = 0; c < SW; c++)
                exp_q.push_back('{due: cyc + 2 + c, id: 2'(w), col: 5'(c), color: rom_f(prow[w], 5'(c))});
            m_ptr = (w + 1) % NR;
            m_end = cyc + SW;
            if (!sticky) pend[w] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = pend;
        exp_q.delete();
        m_ptr = 0;
        m_end = 0;
        #1;
        chk("rst_px_valid", 32'(px_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_px_last", 32'(px_last), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        px_t e;
        logic exp_busy;
        forever begin
            @(posedge clk);
            #1;
            exp_busy = (exp_q.size() > 0) && (exp_q[0].due <= cyc + 1);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("px_valid", 32'(px_valid), 1);
                chk("px_id", 32'(px_id), 32'(e.id));
                chk("px_col", 32'(px_col), 32'(e.col));
                chk("px_color", 32'(px_color), 32'(e.color));
                chk("px_opaque", 32'(px_opaque), 32'(e.color != TRANSP));
                chk("px_last", 32'(px_last), 32'(e.col == 5'(SW - 1)));
            end else begin
                chk("px_valid_idle", 32'(px_valid), 0);
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < NR; i++) prow[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_px_valid", 32'(px_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rom_row", 32'(rom_row), 0);
        chk("reset_rom_col", 32'(rom_col), 0);
        chk("reset_px_last", 32'(px_last), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // single request, row 0
        en = 1'b1;
        pend = 4'b0001;
        repeat (40) step();

        // fairness with all requests held
        sticky = 1'b1;
        for (int i = 0; i < NR; i++) prow[i] = 5'($urandom_range(0, 31));
        pend = 4'b1111;
        repeat (4 * SW + 2) step();
        sticky = 1'b0;
        pend = '0;
        repeat (40) step();

        // enable gating
        en = 1'b0;
        pend = 4'b0100;
        repeat (6) step();
        en = 1'b1;
        step();
        repeat (3) step();
        en = 1'b0;
        repeat (40) step();
        en = 1'b1;

        // pointer wrap
        pend = 4'b1000;
        step();
        pend = 4'b1001;
        repeat (100) step();

        // reset mid-burst
        prow[1] = 5'd7;
        pend = 4'b0010;
        step();
        repeat (12) step();
        pend = 4'b1111;
        do_reset();
        pend = '0;
        repeat (5) step();
        pend = 4'b1010;
        repeat (80) step();

        // withdrawn request outside the slot
        pend = 4'b0001;
        step();
        repeat (5) step();
        pend[1] = 1'b1;
        step();
        pend[1] = 1'b0;
        repeat (40) step();

        // randomized traffic
        repeat (1500) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b1;
                    prow[i] = 5'($urandom_range(0, 31));
                end else if (pend[i] && $urandom_range(0, 31) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        pend = '0;
        en = 1'b1;
        repeat (40) step();

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
